imem_loader: RTL and testbench

- Boot-time writer for the instruction memory. The core's fetch stage reads that memory through its read-only port; this block drives the write side.
- Accepts a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Verifies a trailing XOR checksum.
- Holds the core in reset until a load completes cleanly.

---
 rtl/loader_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 35 +++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words; word_valid pulses with the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_lanes;
  logic [1:0]  r_byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lanes    <= 24'd0;
      r_byte_idx <= 2'd0;
    end else if (i_valid) begin
      case (r_byte_idx)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: ;
      endcase
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

  // The top byte lane is taken straight from the input so the word is ready on the 4th byte.
  assign o_word_valid = i_valid && (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {i_byte, r_lanes};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, XOR-checked,
// holding the core in reset until a clean load completes.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  state_t           r_state;
  logic [15:0]      r_len;
  logic [IDX_W-1:0] r_word_idx;
  logic [7:0]       r_csum;
  logic             r_imem_we;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_imem_wdata;
  logic             r_core_hold;
  logic             r_load_done;
  logic             r_load_err;

  logic        w_xfer;
  logic        w_asm_valid;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic [15:0] w_len_full;
  logic        w_last_word;
  logic [31:0] w_word_addr;

  assign rx_ready    = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer      = rx_valid && rx_ready;
  assign w_asm_valid = w_xfer && (r_state == S_DATA);
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);
  assign w_word_addr = BASE_ADDR + (32'(r_word_idx) << 2);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (w_asm_valid),
    .i_byte       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LEN0;
      r_len        <= 16'd0;
      r_word_idx   <= '0;
      r_csum       <= 8'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= BASE_ADDR;
      r_imem_wdata <= 32'd0;
      r_core_hold  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_LEN0: begin
            r_len[7:0] <= rx_data;
            r_csum     <= csum_fold(r_csum, rx_data);
            r_state    <= S_LEN1;
          end
          S_LEN1: begin
            r_len[15:8] <= rx_data;
            r_csum      <= csum_fold(r_csum, rx_data);
            if (w_len_full > 16'(DEPTH)) begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end else if (w_len_full == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_csum <= csum_fold(r_csum, rx_data);
            if (w_word_valid) begin
              r_imem_we    <= 1'b1;
              r_imem_wdata <= w_word;
              r_imem_addr  <= w_word_addr;
              r_word_idx   <= r_word_idx + 1'b1;
              if (w_last_word) r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_data == r_csum) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
              r_core_hold <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_hold  = r_core_hold;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stream[$];
  logic [63:0] got_w[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) got_w.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_we",       64'(imem_we), 64'd0);
    check("rst_addr",     64'(imem_addr), 64'(BASE));
    check("rst_wdata",    64'(imem_wdata), 64'd0);
    check("rst_hold",     64'(core_hold), 64'd1);
    check("rst_done",     64'(load_done), 64'd0);
    check("rst_err",      64'(load_err), 64'd0);
  endtask

  task automatic apply_reset(input bit do_check);
    rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1 if (do_check) check_reset_vals();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    if (do_check) check_reset_vals();
    got_w.delete();
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'd0;
    foreach (stream[k]) x ^= stream[k];
    return x;
  endfunction

  task automatic build_random(input int n, input bit bad);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int k = 0; k < 4 * n; k++) stream.push_back(8'($urandom));
    stream.push_back(xor_all() ^ {7'd0, bad});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_we, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    check("rx_ready", 64'(rx_ready), 64'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    check("we_latency", 64'(imem_we), 64'(exp_we));
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Reference: decode the stream from its format rules, then drive it and compare.
  task automatic run_load(input int gap_max);
    int          n;
    int          nsend;
    bit          ovf;
    bit          exp_done;
    logic [7:0]  cs;
    logic [63:0] exp_w[$];
    apply_reset(1'b0);
    n   = int'({stream[1], stream[0]});
    ovf = n > DEPTH;
    exp_w.delete();
    if (!ovf) begin
      for (int i = 0; i < n; i++)
        exp_w.push_back({BASE + 32'(4 * i), stream[2+4*i+3], stream[2+4*i+2],
                         stream[2+4*i+1], stream[2+4*i]});
      cs = 8'd0;
      for (int k = 0; k < 2 + 4 * n; k++) cs ^= stream[k];
      exp_done = (stream[2+4*n] == cs);
      nsend    = 3 + 4 * n;
    end else begin
      exp_done = 1'b0;
      nsend    = 2;
    end
    for (int j = 0; j < nsend; j++)
      send_byte(stream[j], !ovf && j >= 2 && j < 2 + 4 * n && ((j - 2) % 4) == 3,
                (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    @(posedge clk); #1;
    check("load_done", 64'(load_done), 64'(exp_done));
    check("load_err",  64'(load_err), 64'(!exp_done));
    check("core_hold", 64'(core_hold), 64'(!exp_done));
    check("rx_ready_end", 64'(rx_ready), 64'd0);
    check("write_count", 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("write%0d", i), got_w[i], exp_w[i]);
    $display("[TB] load N=%0d gap_max=%0d done=%0b err=%0b writes=%0d",
             n, gap_max, load_done, load_err, got_w.size());
  endtask

  initial begin
    @(posedge clk); #1;
    apply_reset(1'b1);

    // Normal two-word load
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    stream.push_back(xor_all());
    check("normal_csum_const", 64'(stream[10]), 64'h73);
    run_load(0);

    // Bad checksum on the same stream
    stream[10] = stream[10] ^ 8'h01;
    run_load(1);

    // Empty load
    stream = '{8'h00, 8'h00, 8'h00};
    run_load(0);

    // Overflow: N = DEPTH+1
    stream = '{8'h41, 8'h00};
    run_load(0);
    rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("ovf_no_accept_err", 64'(load_err), 64'd1);
    check("ovf_no_write", 64'(got_w.size()), 64'd0);

    // Gapped bytes, then asynchronous reset after 5 payload bytes
    build_random(3, 1'b0);
    apply_reset(1'b0);
    for (int j = 0; j < 7; j++) send_byte(stream[j], j == 5, int'($urandom_range(1, 3)));
    check("gap_word0", got_w.size() > 0 ? got_w[0] : 64'd0,
          {BASE, stream[5], stream[4], stream[3], stream[2]});
    #2 reset = 1'b1;
    #1 check_reset_vals();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();
    build_random(4, 1'b0);
    run_load(2);

    // Full-rate DEPTH-word image
    build_random(DEPTH, 1'b0);
    run_load(0);
    check("final_addr", 64'(imem_addr), 64'(BASE + 32'(4 * (DEPTH - 1))));

    // Random loads
    for (int t = 0; t < 6; t++) begin
      build_random(int'($urandom_range(0, DEPTH + 1)), $urandom_range(0, 3) == 0);
      run_load(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
